// File: rtl/kirsch_pkg.sv
// Shared constants and helpers for the Kirsch compass edge pipeline.
// Widths are expressed as functions of the pixel width so every stage sizes itself from PW.
package kirsch_pkg;

    localparam int NDIR  = 8;
    localparam int DIR_W = 3;

    // Window index (p1 = 0 .. p9 = 8) of each ring position, clockwise from the top-left corner.
    localparam int RING [NDIR] = '{0, 1, 2, 5, 8, 7, 6, 3};

    localparam int PW_DEFAULT   = 8;
    localparam int SUM3_W_DEF   = PW_DEFAULT + 2;
    localparam int SUM8_W_DEF   = PW_DEFAULT + 3;
    localparam int RESP_W_DEF   = PW_DEFAULT + 6;

    function automatic int sum3_w(input int pw);
        return pw + 2;
    endfunction

    function automatic int sum8_w(input int pw);
        return pw + 3;
    endfunction

    function automatic int resp_w(input int pw);
        return pw + 6;
    endfunction

    function automatic logic [31:0] clamp(input logic signed [31:0] r, input int pw);
        logic signed [31:0] maxv;
        maxv = (32'sd1 <<< pw) - 32'sd1;
        if (r < 0) return '0;
        if (r > maxv) return maxv;
        return r;
    endfunction

endpackage

// File: rtl/kirsch_compass_stream_if.sv
// Pixel-in / edge-out stream bundle; slave is the detector's view, master the source/sink side.
interface kirsch_compass_stream_if #(parameter int PW = 8);
    logic                         s_valid;
    logic                         s_ready;
    logic [PW-1:0]                s_data;
    logic                         s_sof;
    logic                         m_valid;
    logic                         m_ready;
    logic [PW-1:0]                m_data;
    logic [kirsch_pkg::DIR_W-1:0] m_dir;
    logic                         m_eol;
    logic                         m_eof;

    modport slave (
        input  s_valid, s_data, s_sof, m_ready,
        output s_ready, m_valid, m_data, m_dir, m_eol, m_eof
    );

    modport master (
        output s_valid, s_data, s_sof, m_ready,
        input  s_ready, m_valid, m_data, m_dir, m_eol, m_eof
    );
endinterface

// File: rtl/kirsch_line_buf.sv
// One-line pixel delay: dout is the pixel written DEPTH advances ago; combinational read, no bypass.
// Contents are not reset; only the pointer is.
module kirsch_line_buf #(
    parameter int PW    = 8,
    parameter int DEPTH = 640
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          adv,
    input  logic [PW-1:0] din,
    output logic [PW-1:0] dout
);
    localparam int AW = $clog2(DEPTH);

    logic [PW-1:0] mem [DEPTH];
    logic [AW-1:0] ptr;

    assign dout = mem[ptr];

    always_ff @(posedge clk) begin
        if (adv) mem[ptr] <= din;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (adv) begin
            ptr <= (ptr == AW'(DEPTH - 1)) ? '0 : ptr + AW'(1);
        end
    end
endmodule

// File: rtl/kirsch_compass_stream.sv
// Streaming 3x3 Kirsch compass detector: window/flags, sums, then response/clamp/select (3 enabled edges).
// Whole pipeline stalls together while an output is held (en = !m_valid || m_ready).
module kirsch_compass_stream
    import kirsch_pkg::*;
#(
    parameter int PW    = 8,
    parameter int IMG_W = 640,
    parameter int IMG_H = 480
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cfg_mode,
    input  logic [DIR_W-1:0]     cfg_dir,
    kirsch_compass_stream_if.slave bus
);
    localparam int SW = sum3_w(PW);
    localparam int TW = sum8_w(PW);
    localparam int RW = resp_w(PW);
    localparam int CW = $clog2(IMG_W);
    localparam int HW = $clog2(IMG_H);

    logic en, acc;
    assign en          = !bus.m_valid || bus.m_ready;
    assign bus.s_ready = en;
    assign acc         = en && bus.s_valid;

    logic [CW-1:0] nxt_col, cur_col;
    logic [HW-1:0] nxt_row, cur_row;
    logic          last_col, last_row;
    logic          cfg_mode_q, mode_cur;
    logic [DIR_W-1:0] cfg_dir_q, dir_cur;

    // s_sof restarts the frame and latches the configuration for the pixel being accepted.
    always_comb begin
        cur_col  = bus.s_sof ? '0 : nxt_col;
        cur_row  = bus.s_sof ? '0 : nxt_row;
        mode_cur = bus.s_sof ? cfg_mode : cfg_mode_q;
        dir_cur  = bus.s_sof ? cfg_dir : cfg_dir_q;
        last_col = (cur_col == CW'(IMG_W - 1));
        last_row = (cur_row == HW'(IMG_H - 1));
    end

    logic [PW-1:0] lb0_out, lb1_out;

    kirsch_line_buf #(.PW(PW), .DEPTH(IMG_W)) u_lb0 (
        .clk(clk), .rst_n(rst_n), .adv(acc), .din(bus.s_data), .dout(lb0_out)
    );
    kirsch_line_buf #(.PW(PW), .DEPTH(IMG_W)) u_lb1 (
        .clk(clk), .rst_n(rst_n), .adv(acc), .din(lb0_out), .dout(lb1_out)
    );

    logic [PW-1:0] win [9];

    always_ff @(posedge clk) begin
        if (acc) begin
            for (int rr = 0; rr < 3; rr++) begin
                win[rr*3]   <= win[rr*3+1];
                win[rr*3+1] <= win[rr*3+2];
            end
            win[2] <= lb1_out;
            win[5] <= lb0_out;
            win[8] <= bus.s_data;
        end
    end

    logic [SW-1:0] s3_nx [NDIR];
    logic [SW-1:0] s3_q  [NDIR];
    logic [TW-1:0] t_nx, t_q;

    always_comb begin
        t_nx = '0;
        for (int k = 0; k < NDIR; k++) begin
            t_nx     = t_nx + TW'(win[RING[k]]);
            s3_nx[k] = SW'(win[RING[k]]) + SW'(win[RING[(k+1)%NDIR]]) + SW'(win[RING[(k+2)%NDIR]]);
        end
    end

    always_ff @(posedge clk) begin
        if (en) begin
            s3_q <= s3_nx;
            t_q  <= t_nx;
        end
    end

    logic                v1, eol1, eof1, mode1, v2, eol2, eof2, mode2;
    logic [DIR_W-1:0]    dir1, dir2;
    logic signed [RW-1:0] resp [NDIR];
    logic [PW-1:0]       clamped [NDIR];
    logic [PW-1:0]       out_data;
    logic [DIR_W-1:0]    out_dir;

    // R = 8*S3 - 3*T; both operands fit PW+6 bits unsigned, so the wrapped difference is exact.
    always_comb begin
        out_data = '0;
        out_dir  = '0;
        for (int k = 0; k < NDIR; k++) begin
            resp[k]    = $signed({1'b0, s3_q[k], 3'b000} - ({2'b00, t_q, 1'b0} + {3'b000, t_q}));
            clamped[k] = PW'(clamp(32'(resp[k]), PW));
        end
        if (mode2) begin
            out_data = clamped[0];
            for (int k = 1; k < NDIR; k++) begin
                if (clamped[k] > out_data) begin
                    out_data = clamped[k];
                    out_dir  = DIR_W'(k);
                end
            end
        end else begin
            out_data = clamped[dir2];
            out_dir  = dir2;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nxt_col     <= '0;
            nxt_row     <= '0;
            cfg_mode_q  <= 1'b0;
            cfg_dir_q   <= '0;
            {v1, eol1, eof1, mode1, dir1} <= '0;
            {v2, eol2, eof2, mode2, dir2} <= '0;
            bus.m_valid <= 1'b0;
            bus.m_data  <= '0;
            bus.m_dir   <= '0;
            bus.m_eol   <= 1'b0;
            bus.m_eof   <= 1'b0;
        end else begin
            if (acc) begin
                cfg_mode_q <= mode_cur;
                cfg_dir_q  <= dir_cur;
                nxt_col    <= last_col ? '0 : cur_col + CW'(1);
                nxt_row    <= !last_col ? cur_row : (last_row ? '0 : cur_row + HW'(1));
            end
            if (en) begin
                v1    <= acc && (cur_row >= HW'(2)) && (cur_col >= CW'(2));
                eol1  <= last_col;
                eof1  <= last_col && last_row;
                mode1 <= mode_cur;
                dir1  <= dir_cur;
                {v2, eol2, eof2, mode2, dir2} <= {v1, eol1, eof1, mode1, dir1};
                bus.m_valid <= v2;
                if (v2) begin
                    bus.m_data <= out_data;
                    bus.m_dir  <= out_dir;
                    bus.m_eol  <= eol2;
                    bus.m_eof  <= eof2;
                end
            end
        end
    end
endmodule

// File: tb/tb_kirsch_compass_stream.sv
// Bench for kirsch_compass_stream: fixed window vectors, stall/config/reset sequences and random frames
// checked against a weight-table reference model.
module tb_kirsch_compass_stream;
    localparam int PW = 8, W = 8, H = 6, NOUT = (W - 2) * (H - 2);

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cfg_mode = 1'b0;
    logic [2:0] cfg_dir = 3'd0;

    always #5 clk = ~clk;

    kirsch_compass_stream_if #(.PW(PW)) bus ();

    kirsch_compass_stream #(.PW(PW), .IMG_W(W), .IMG_H(H)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_mode(cfg_mode), .cfg_dir(cfg_dir), .bus(bus)
    );

    typedef struct packed {
        logic [7:0] data;
        logic [2:0] dir;
        logic       eol;
        logic       eof;
    } out_t;

    typedef struct {
        int   v;
        logic mode;
        int   dir;
        int   exp_data;
        int   exp_dir;
    } vec_t;

    int n_pass = 0, n_chk = 0;
    int ringi [8] = '{0, 1, 2, 5, 8, 7, 6, 3};
    int img [H][W];
    int m_row = 0, m_col = 0;
    logic m_mode = 1'b0;
    int m_dir = 0;
    out_t exp_q[$];
    out_t rx_q[$];
    int stall_left = 0;
    bit rand_ready = 1'b0;
    bit bubbles = 1'b0;
    out_t snap;

    task automatic check(input string name, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    endtask

    function automatic out_t model_out(input int r, input int c, input logic mode, input int dir);
        int p [9];
        int val [8];
        int s, best;
        out_t o;
        for (int i = 0; i < 9; i++) p[i] = img[r - 2 + i / 3][c - 2 + i % 3];
        for (int k = 0; k < 8; k++) begin
            s = 0;
            for (int j = 0; j < 8; j++)
                s += ((((j - k + 8) % 8) < 3) ? 5 : -3) * p[ringi[j]];
            val[k] = (s < 0) ? 0 : ((s > 255) ? 255 : s);
        end
        if (!mode) begin
            o.data = 8'(val[dir]);
            o.dir  = 3'(dir);
        end else begin
            best = -1;
            o.dir = 3'd0;
            for (int k = 0; k < 8; k++) begin
                if (val[k] > best) begin
                    best  = val[k];
                    o.dir = 3'(k);
                end
            end
            o.data = 8'(best);
        end
        o.eol = (c == W - 1);
        o.eof = (c == W - 1) && (r == H - 1);
        return o;
    endfunction

    task automatic model_reset();
        exp_q.delete();
        m_row = 0;
        m_col = 0;
        m_mode = 1'b0;
        m_dir = 0;
    endtask

    task automatic model_accept(input int d, input logic sof);
        int r, c;
        if (sof) begin
            r = 0; c = 0; m_mode = cfg_mode; m_dir = int'(cfg_dir);
        end else begin
            r = m_row; c = m_col;
        end
        img[r][c] = d;
        if (r >= 2 && c >= 2) exp_q.push_back(model_out(r, c, m_mode, m_dir));
        m_col = (c == W - 1) ? 0 : c + 1;
        m_row = (c != W - 1) ? r : ((r == H - 1) ? 0 : r + 1);
    endtask

    task automatic cycle(input logic v, input logic [7:0] d, input logic sof, output logic acc);
        out_t got;
        @(negedge clk);
        bus.s_valid = v;
        bus.s_data  = d;
        bus.s_sof   = sof;
        if (stall_left > 0) bus.m_ready = 1'b0;
        else bus.m_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
        #1;
        got = {bus.m_data, bus.m_dir, bus.m_eol, bus.m_eof};
        acc = v && bus.s_ready;
        if (stall_left > 0) begin
            if (stall_left == 5) snap = got;
            else check("stall_hold", int'(got), int'(snap));
            check("stall_mvalid", int'(bus.m_valid), 1);
            check("stall_sready", int'(bus.s_ready), 0);
            stall_left--;
        end
        if (bus.m_valid && bus.m_ready) begin
            rx_q.push_back(got);
            if (exp_q.size() == 0) check("unexpected_out", int'(got), -1);
            else check("scoreboard", int'(got), int'(exp_q.pop_front()));
        end
        if (acc) model_accept(int'(d), sof);
    endtask

    task automatic send_px(input logic [7:0] d, input logic sof);
        logic a;
        int tries = 0;
        if (bubbles && $urandom_range(0, 3) == 0) cycle(1'b0, 8'($urandom), 1'b0, a);
        do begin
            cycle(1'b1, d, sof, a);
            tries++;
        end while (!a && tries < 200);
        if (!a) check("accept_timeout", 0, 1);
    endtask

    task automatic drain();
        logic a;
        int n = 0;
        while ((exp_q.size() != 0 || bus.m_valid) && n < 200) begin
            cycle(1'b0, 8'd0, 1'b0, a);
            n++;
        end
        check("drain_timeout", int'(n < 200), 1);
    endtask

    // pat: 0 flat 100, 1 column 4 = v else 0, 2 random
    task automatic send_frame(input int pat, input int v, input int npx,
                              input int chg_at, input int new_dir, input int stall_at);
        int px, idx;
        rx_q.delete();
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                idx = r * W + c;
                if (idx < npx) begin
                    px = (pat == 0) ? 100 : ((pat == 1) ? ((c == 4) ? v : 0) : int'($urandom_range(0, 255)));
                    if (idx == chg_at) cfg_dir = 3'(new_dir);
                    if (idx == stall_at) stall_left = 5;
                    send_px(8'(px), (r == 0) && (c == 0));
                end
            end
        end
    endtask

    task automatic check_all_dir(input string name, input int d);
        int errs = 0;
        foreach (rx_q[i]) if (int'(rx_q[i].dir) != d) errs++;
        check(name, errs, 0);
        check({name, "_cnt"}, rx_q.size(), NOUT);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t tbl [5];
        int errs;
        logic a;

        tbl[0] = '{10,  1'b1, 0, 150, 2};
        tbl[1] = '{10,  1'b0, 1, 70,  1};
        tbl[2] = '{10,  1'b0, 6, 0,   6};
        tbl[3] = '{200, 1'b0, 2, 255, 2};
        tbl[4] = '{200, 1'b0, 6, 0,   6};

        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        bus.s_sof   = 1'b0;
        bus.m_ready = 1'b1;
        model_reset();

        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        check("rst_m_valid", int'(bus.m_valid), 0);
        check("rst_m_data", int'(bus.m_data), 0);
        check("rst_m_dir", int'(bus.m_dir), 0);
        check("rst_m_eol_eof", int'({bus.m_eol, bus.m_eof}), 0);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        check("rst_s_ready", int'(bus.s_ready), 1);

        // flat image in max mode: all responses zero, ties to direction 0
        cfg_mode = 1'b1;
        send_frame(0, 0, W * H, -1, 0, -1);
        drain();
        check("flat_count", rx_q.size(), NOUT);
        errs = 0;
        foreach (rx_q[i]) begin
            if (rx_q[i].data != 8'd0 || rx_q[i].dir != 3'd0) errs++;
            if (rx_q[i].eol != ((i % (W - 2)) == (W - 3))) errs++;
            if (rx_q[i].eof != (i == NOUT - 1)) errs++;
        end
        check("flat_flags", errs, 0);

        // fixed windows: right column = v, everything else 0 (output index 2 is window at col 4)
        for (int i = 0; i < 5; i++) begin
            cfg_mode = tbl[i].mode;
            cfg_dir  = 3'(tbl[i].dir);
            send_frame(1, tbl[i].v, W * H, -1, 0, -1);
            drain();
            check($sformatf("tbl%0d_cnt", i), rx_q.size(), NOUT);
            if (rx_q.size() > 2) begin
                check($sformatf("tbl%0d_data", i), int'(rx_q[2].data), tbl[i].exp_data);
                check($sformatf("tbl%0d_dir", i), int'(rx_q[2].dir), tbl[i].exp_dir);
            end
        end

        // 5-cycle output stall mid-row
        cfg_mode = 1'b1;
        send_frame(2, 0, W * H, -1, 0, 30);
        drain();
        check("stall_count", rx_q.size(), NOUT);

        // configuration change mid-frame only takes effect at the next s_sof
        cfg_mode = 1'b0;
        cfg_dir  = 3'd2;
        send_frame(2, 0, W * H, 20, 5, -1);
        drain();
        check_all_dir("cfg_hold_dir2", 2);
        send_frame(2, 0, W * H, -1, 0, -1);
        drain();
        check_all_dir("cfg_next_dir5", 5);

        // random frames back to back with bubbles, random ready and one truncated frame
        bubbles = 1'b1;
        rand_ready = 1'b1;
        for (int f = 0; f < 6; f++) begin
            cfg_mode = 1'($urandom);
            cfg_dir  = 3'($urandom);
            send_frame(2, 0, (f == 2) ? 29 : W * H, -1, 0, -1);
        end
        drain();

        // reset mid-frame, then a fresh frame
        bubbles = 1'b0;
        rand_ready = 1'b0;
        cfg_mode = 1'b1;
        send_frame(2, 0, 30, -1, 0, -1);
        @(negedge clk);
        rst_n = 1'b0;
        bus.s_valid = 1'b0;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            check("midrst_m_valid", int'(bus.m_valid), 0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        cycle(1'b0, 8'd0, 1'b0, a);
        send_frame(2, 0, W * H, -1, 0, -1);
        drain();
        check("midrst_count", rx_q.size(), NOUT);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
